aes_gcm_decrypt: RTL and testbench

AES-128-GCM authenticated decryption engine. It is the receive-side counterpart of the GCM encryption top and reuses the existing aes_encrypt (CTR keystream) and ghash (authentication) blocks. GHASH runs over the incoming ciphertext while the CTR keystream recovers plaintext. At the end, the block compares the recomputed tag against the received tag and reports pass/fail.
Supports a 96-bit IV and block-aligned AAD and ciphertext.

---
 rtl/aes_gcm_pkg.sv | 30 +++
 rtl/aes_gcm_decrypt_if.sv | 32 +++
 rtl/aes_encrypt.sv | 115 +++++++++++
 rtl/gcm_ctr_pipe.sv | 36 +++
 rtl/ghash.sv | 58 +++++
 rtl/aes_gcm_decrypt.sv | 162 ++++++++++++++++
 tb/tb_aes_gcm_decrypt.sv | 273 +++++++++++++++++++++++++++
 7 files changed

// File: rtl/aes_gcm_pkg.sv
// Shared GCM definitions: FSM encoding, block constants and counter/J0 helpers.
package aes_gcm_pkg;

  localparam int AES_LAT = 11;
  localparam int BLK     = 128;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_H,
    S_SEND_J0,
    S_WAIT_J0,
    S_AAD,
    S_CT,
    S_DRAIN,
    S_LEN,
    S_WAIT_GHASH,
    S_DONE
  } gcm_state_t;

  // Increment the low 32 bits modulo 2^32; the upper 96 bits never change.
  function automatic logic [BLK-1:0] inc32(input logic [BLK-1:0] c);
    return {c[BLK-1:32], c[31:0] + 32'd1};
  endfunction

  // Pre-counter block for a 96-bit IV.
  function automatic logic [BLK-1:0] make_j0(input logic [95:0] iv);
    return {iv, 31'd0, 1'b1};
  endfunction

endpackage

// File: rtl/aes_gcm_decrypt_if.sv
// Message-level bus of the GCM decryptor: key/IV/tag, AAD and CT streams, PT and status.
interface aes_gcm_decrypt_if;
  logic [127:0] key;
  logic [95:0]  iv;
  logic [127:0] tag_in;
  logic         start;
  logic         busy;
  logic [127:0] aad_data;
  logic         aad_valid;
  logic         aad_last;
  logic         aad_ready;
  logic [127:0] ct_data;
  logic         ct_valid;
  logic         ct_last;
  logic         ct_ready;
  logic [127:0] pt_data;
  logic         pt_valid;
  logic         done;
  logic         auth_ok;

  modport master (
    output key, iv, tag_in, start, aad_data, aad_valid, aad_last,
           ct_data, ct_valid, ct_last,
    input  busy, aad_ready, ct_ready, pt_data, pt_valid, done, auth_ok
  );

  modport slave (
    input  key, iv, tag_in, start, aad_data, aad_valid, aad_last,
           ct_data, ct_valid, ct_last,
    output busy, aad_ready, ct_ready, pt_data, pt_valid, done, auth_ok
  );
endinterface

// File: rtl/aes_encrypt.sv
// Fully pipelined AES-128 encryptor: initial AddRoundKey stage plus ten round stages.
module aes_encrypt (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic         valid_in,
  input  logic [127:0] data_in,
  output logic         valid_out,
  output logic [127:0] data_out
);

  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
    x2   = gmul(a, a);
    x4   = gmul(x2, x2);
    x8   = gmul(x4, x4);
    x16  = gmul(x8, x8);
    x32  = gmul(x16, x16);
    x64  = gmul(x32, x32);
    x128 = gmul(x64, x64);
    inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte i of the state is bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0] b  [16];
    logic [7:0] sr [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (last)
        o[127-32*c -: 32] = {a0, a1, a2, a3};
      else
        o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ rk;
  endfunction

  logic [127:0] st_p   [0:10];
  logic [127:0] rk_p   [0:9];
  logic [127:0] rk_nxt [1:10];
  logic [10:0]  vld_p;

  // Round keys for each stage derived from the key travelling alongside the data.
  always_comb begin
    for (int r = 1; r <= 10; r++) rk_nxt[r] = next_key(rk_p[r-1], RCON[r]);
  end

  // Stage 0 whitens with the cipher key; stages 1..10 apply the rounds.
  always_ff @(posedge clk) begin
    st_p[0] <= data_in ^ key;
    rk_p[0] <= key;
    for (int r = 1; r <= 10; r++) begin
      st_p[r] <= aes_round(st_p[r-1], rk_nxt[r], r == 10);
      if (r < 10) rk_p[r] <= rk_nxt[r];
    end
  end

  // Valid bits shift with the data.
  always_ff @(posedge clk) begin
    if (rst) vld_p <= '0;
    else     vld_p <= {vld_p[9:0], valid_in};
  end

  assign valid_out = vld_p[10];
  assign data_out  = st_p[10];

endmodule

// File: rtl/gcm_ctr_pipe.sv
// Holds ciphertext blocks until their keystream emerges, then XORs them into plaintext.
module gcm_ctr_pipe #(
  parameter int STAGES = 12,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] ct_in,
  input  logic [DATA_W-1:0] ks,
  input  logic              ks_vld,
  output logic [DATA_W-1:0] pt_data,
  output logic              pt_valid,
  output logic              inflight
);

  logic [DATA_W-1:0] ct_p [STAGES];
  logic [STAGES-1:0] vld_p;

  // Ciphertext alignment shift register.
  always_ff @(posedge clk) begin
    ct_p[0] <= ct_in;
    for (int i = 1; i < STAGES; i++) ct_p[i] <= ct_p[i-1];
  end

  // Block-present flags; cleared on reset so an aborted message leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) vld_p <= '0;
    else     vld_p <= {vld_p[STAGES-2:0], push};
  end

  assign pt_valid = vld_p[STAGES-1] & ks_vld;
  assign pt_data  = pt_valid ? (ct_p[STAGES-1] ^ ks) : '0;
  assign inflight = |vld_p;

endmodule

// File: rtl/ghash.sv
// GHASH accumulator: one block per accepted beat, one idle cycle between blocks.
module ghash (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] h,
  input  logic [127:0] data_in,
  input  logic         data_valid,
  input  logic         data_last,
  output logic         ready,
  output logic [127:0] result,
  output logic         result_valid
);

  // GF(2^128) product in GCM bit order (bit 127 of the vector is polynomial x^0).
  function automatic logic [127:0] gf_mult(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = '0;
    v = y;
    for (int i = 127; i >= 0; i--) begin
      if (x[i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'd0}) : (v >> 1);
    end
    return z;
  endfunction

  logic [127:0] h_q, y_q;
  logic         bubble_q, res_vld_q;
  logic         accept;

  assign ready  = !bubble_q;
  assign accept = data_valid && ready;

  // Accept pacing and the end-of-message result strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q  <= 1'b0;
      res_vld_q <= 1'b0;
    end else begin
      bubble_q  <= accept;
      res_vld_q <= accept && data_last;
    end
  end

  // Hash subkey capture and running accumulator.
  always_ff @(posedge clk) begin
    if (start) begin
      h_q <= h;
      y_q <= '0;
    end else if (accept) begin
      y_q <= gf_mult(y_q ^ data_in, h_q);
    end
  end

  assign result       = y_q;
  assign result_valid = res_vld_q;

endmodule

// File: rtl/aes_gcm_decrypt.sv
// AES-128-GCM authenticated decryption: CTR plaintext recovery plus tag verification.
module aes_gcm_decrypt
  import aes_gcm_pkg::*;
#(
  parameter int TAG_BITS = 128,
  parameter int PT_LAT   = AES_LAT + 1
) (
  input  logic clk,
  input  logic rst,
  aes_gcm_decrypt_if.slave bus
);

  localparam logic [BLK-1:0] TAG_MASK = ~((BLK'(1) << (BLK - TAG_BITS)) - BLK'(1));

  gcm_state_t     state_q, state_d;
  logic [BLK-1:0] h_q, ej0_q, tag_q, ctr_q;
  logic [63:0]    aad_bits_q, ct_bits_q;
  logic           aes_vld_p0;
  logic [BLK-1:0] aes_din_p0;
  logic           aes_issue;
  logic [BLK-1:0] aes_issue_data;
  logic           aes_vout;
  logic [BLK-1:0] aes_dout;
  logic           gh_start, gh_vld, gh_last, gh_ready, gh_res_vld;
  logic [BLK-1:0] gh_data, gh_res;
  logic           aad_rdy, ct_rdy, aad_acc, ct_acc, pipe_busy;
  logic [BLK-1:0] tag_diff;

  assign aad_rdy = (state_q == S_AAD) && gh_ready;
  assign ct_rdy  = (state_q == S_CT) && gh_ready;
  assign aad_acc = aad_rdy && bus.aad_valid;
  assign ct_acc  = ct_rdy && bus.ct_valid;

  // Next state plus the AES issue and GHASH feed for the current state.
  always_comb begin
    state_d        = state_q;
    aes_issue      = 1'b0;
    aes_issue_data = ctr_q;
    gh_start       = 1'b0;
    gh_vld         = 1'b0;
    gh_data        = bus.aad_data;
    gh_last        = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        aes_issue      = 1'b1;
        aes_issue_data = '0;
        state_d        = S_WAIT_H;
      end
      S_WAIT_H:  if (aes_vout) state_d = S_SEND_J0;
      S_SEND_J0: begin
        aes_issue      = 1'b1;
        aes_issue_data = make_j0(bus.iv);
        gh_start       = 1'b1;
        state_d        = S_WAIT_J0;
      end
      S_WAIT_J0: if (aes_vout) state_d = S_AAD;
      S_AAD: begin
        if (aad_acc) begin
          gh_vld = 1'b1;
          if (bus.aad_last) state_d = S_CT;
        end else if (bus.aad_last && !bus.aad_valid) begin
          state_d = S_CT;
        end
      end
      S_CT: begin
        gh_data = bus.ct_data;
        if (ct_acc) begin
          gh_vld    = 1'b1;
          aes_issue = 1'b1;
          if (bus.ct_last) state_d = S_DRAIN;
        end else if (bus.ct_last && !bus.ct_valid) begin
          state_d = S_LEN;
        end
      end
      S_DRAIN: if (!pipe_busy && gh_ready) state_d = S_LEN;
      S_LEN: begin
        gh_data = {aad_bits_q, ct_bits_q};
        if (gh_ready) begin
          gh_vld  = 1'b1;
          gh_last = 1'b1;
          state_d = S_WAIT_GHASH;
        end
      end
      S_WAIT_GHASH: if (gh_res_vld) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Control registers: FSM state and the AES input-register valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      aes_vld_p0 <= 1'b0;
    end else begin
      state_q    <= state_d;
      aes_vld_p0 <= aes_issue;
    end
  end

  // Per-message data: tag, H, E(K,J0), counter, bit lengths and the AES input block.
  always_ff @(posedge clk) begin
    aes_din_p0 <= aes_issue_data;
    if (state_q == S_IDLE && bus.start) begin
      tag_q      <= bus.tag_in;
      aad_bits_q <= '0;
      ct_bits_q  <= '0;
    end
    if (state_q == S_WAIT_H && aes_vout)  h_q   <= aes_dout;
    if (state_q == S_SEND_J0)             ctr_q <= {bus.iv, 32'd2};
    if (state_q == S_WAIT_J0 && aes_vout) ej0_q <= aes_dout;
    if (aad_acc) aad_bits_q <= aad_bits_q + 64'd128;
    if (ct_acc) begin
      ct_bits_q <= ct_bits_q + 64'd128;
      ctr_q     <= inc32(ctr_q);
    end
  end

  aes_encrypt u_aes (
    .clk       (clk),
    .rst       (rst),
    .key       (bus.key),
    .valid_in  (aes_vld_p0),
    .data_in   (aes_din_p0),
    .valid_out (aes_vout),
    .data_out  (aes_dout)
  );

  ghash u_ghash (
    .clk          (clk),
    .rst          (rst),
    .start        (gh_start),
    .h            (h_q),
    .data_in      (gh_data),
    .data_valid   (gh_vld),
    .data_last    (gh_last),
    .ready        (gh_ready),
    .result       (gh_res),
    .result_valid (gh_res_vld)
  );

  gcm_ctr_pipe #(.STAGES(PT_LAT), .DATA_W(BLK)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .push     (ct_acc),
    .ct_in    (bus.ct_data),
    .ks       (aes_dout),
    .ks_vld   (aes_vout),
    .pt_data  (bus.pt_data),
    .pt_valid (bus.pt_valid),
    .inflight (pipe_busy)
  );

  // Constant-time compare of the truncated tag: every bit is examined.
  assign tag_diff      = ((ej0_q ^ gh_res) ^ tag_q) & TAG_MASK;
  assign bus.done      = (state_q == S_DONE);
  assign bus.auth_ok   = bus.done && ~|tag_diff;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.aad_ready = aad_rdy;
  assign bus.ct_ready  = ct_rdy;

endmodule

// File: tb/tb_aes_gcm_decrypt.sv
// Directed bench for aes_gcm_decrypt using the published GCM test vectors.
module tb_aes_gcm_decrypt;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_gcm_decrypt_if g ();
  aes_gcm_decrypt_if g96 ();

  assign g96.key       = g.key;
  assign g96.iv        = g.iv;
  assign g96.tag_in    = g.tag_in;
  assign g96.start     = g.start;
  assign g96.aad_data  = g.aad_data;
  assign g96.aad_valid = g.aad_valid;
  assign g96.aad_last  = g.aad_last;
  assign g96.ct_data   = g.ct_data;
  assign g96.ct_valid  = g.ct_valid;
  assign g96.ct_last   = g.ct_last;

  aes_gcm_decrypt #(.TAG_BITS(128)) dut   (.clk(clk), .rst(rst), .bus(g.slave));
  aes_gcm_decrypt #(.TAG_BITS(96))  dut96 (.clk(clk), .rst(rst), .bus(g96.slave));

  localparam logic [127:0] T1  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] C2  = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] T2  = 128'hab6e47d42cec13bdf53a67b21257bddf;
  localparam logic [127:0] K3  = 128'hfeffe9928665731c6d6a8f9467308308;
  localparam logic [95:0]  IV3 = 96'hcafebabefacedbaddecaf888;
  localparam logic [127:0] T3  = 128'h4d5c2af327cd64a62cf35abd2ba6fab4;
  localparam logic [127:0] C3 [4] = '{128'h42831ec2217774244b7221b784d0d49c,
                                      128'he3aa212f2c02a4e035c17e2329aca12e,
                                      128'h21d514b25466931c7d8f6a5aac84aa05,
                                      128'h1ba30b396a0aac973d58e091473f5985};
  localparam logic [127:0] P3 [4] = '{128'hd9313225f88406e5a55909c5aff5269a,
                                      128'h86a7a9531534f7da2e4c303d8a318a72,
                                      128'h1c3c0c95956809532fcf0e2449a6b525,
                                      128'hb16aedf5aa0de657ba637b391aafd255};

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [127:0] pt_q [$];
  int           pt_cyc [$];
  int           acc_cyc [$];
  int           done_cnt = 0;
  int           done_cyc = 0;
  logic         auth_last = 1'b0;
  logic         auth96_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record plaintext beats, ciphertext acceptances and done pulses between edges.
  always @(negedge clk) begin
    if (g.pt_valid) begin
      pt_q.push_back(g.pt_data);
      pt_cyc.push_back(cyc);
    end
    if (g.ct_valid && g.ct_ready) acc_cyc.push_back(cyc);
    if (g.done) begin
      done_cnt    = done_cnt + 1;
      done_cyc    = cyc;
      auth_last   = g.auth_ok;
      auth96_last = g96.auth_ok;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_mon();
    pt_q.delete();
    pt_cyc.delete();
    acc_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [127:0] k, input logic [95:0] iv, input logic [127:0] tag);
    @(posedge clk); #1;
    g.key = k; g.iv = iv; g.tag_in = tag; g.start = 1'b1;
    @(posedge clk); #1;
    g.start = 1'b0;
  endtask

  // Present one beat (or a bare last marker when v=0) and hold it until ready.
  task automatic send_beat(input bit is_ct, input logic [127:0] d, input bit v, input bit last,
                           input int gap);
    int n;
    repeat (gap) @(posedge clk);
    #1;
    if (is_ct) begin g.ct_data = d;  g.ct_valid = v;  g.ct_last = last;  end
    else       begin g.aad_data = d; g.aad_valid = v; g.aad_last = last; end
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (is_ct ? g.ct_ready : g.aad_ready) break;
    end
    if (n == 300) begin
      checks++; errors++;
      $display("FAIL beat_timeout: ready never seen for %s beat", is_ct ? "ct" : "aad");
    end
    @(posedge clk); #1;
    if (is_ct) begin g.ct_valid = 1'b0;  g.ct_last = 1'b0;  end
    else       begin g.aad_valid = 1'b0; g.aad_last = 1'b0; end
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 1000; n++) begin
      @(posedge clk);
      if (done_cnt > 0) break;
    end
    if (n == 1000) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done pulse within 1000 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic run_case2(input logic [127:0] tag);
    clear_mon();
    do_start('0, '0, tag);
    send_beat(1'b0, '0, 1'b0, 1'b1, 0);
    send_beat(1'b1, C2, 1'b1, 1'b1, 0);
    wait_done();
  endtask

  task automatic run_case3(input bit random_gaps);
    clear_mon();
    do_start(K3, IV3, T3);
    // A second start with a different tag while busy must be ignored.
    g.start = 1'b1; g.tag_in = ~T3;
    @(posedge clk); #1;
    g.start = 1'b0; g.tag_in = T3;
    send_beat(1'b0, '0, 1'b0, 1'b1, random_gaps ? $urandom_range(0, 3) : 0);
    for (int i = 0; i < 4; i++)
      send_beat(1'b1, C3[i], 1'b1, i == 3, random_gaps ? $urandom_range(0, 3) : 0);
    wait_done();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (g.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", g.busy); end
    checks++; if (g.done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", g.done); end
    checks++; if (g.auth_ok !== 1'b0)   begin errors++; $display("FAIL reset_auth_ok: got %b expected 0", g.auth_ok); end
    checks++; if (g.pt_valid !== 1'b0)  begin errors++; $display("FAIL reset_pt_valid: got %b expected 0", g.pt_valid); end
    checks++; if (g.pt_data !== '0)     begin errors++; $display("FAIL reset_pt_data: got %h expected 0", g.pt_data); end
    checks++; if (g.aad_ready !== 1'b0) begin errors++; $display("FAIL reset_aad_ready: got %b expected 0", g.aad_ready); end
    checks++; if (g.ct_ready !== 1'b0)  begin errors++; $display("FAIL reset_ct_ready: got %b expected 0", g.ct_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_empty_message();
    clear_mon();
    do_start('0, '0, T1);
    checks++; if (g.busy !== 1'b1) begin errors++; $display("FAIL case1_busy: got %b expected 1", g.busy); end
    send_beat(1'b0, '0, 1'b0, 1'b1, 0);
    send_beat(1'b1, '0, 1'b0, 1'b1, 0);
    wait_done();
    checks++; if (pt_q.size() != 0) begin errors++; $display("FAIL case1_pt_count: got %0d expected 0", pt_q.size()); end
    checks++; if (done_cnt != 1)    begin errors++; $display("FAIL case1_done_count: got %0d expected 1", done_cnt); end
    checks++; if (auth_last !== 1'b1)   begin errors++; $display("FAIL case1_auth_ok: got %b expected 1", auth_last); end
    checks++; if (auth96_last !== 1'b1) begin errors++; $display("FAIL case1_auth_ok_96: got %b expected 1", auth96_last); end
    checks++; if (g.busy !== 1'b0)  begin errors++; $display("FAIL case1_busy_after: got %b expected 0", g.busy); end
  endtask

  task automatic test_single_block();
    run_case2(T2);
    checks++;
    if (pt_q.size() != 1) begin
      errors++; $display("FAIL case2_pt_count: got %0d expected 1", pt_q.size());
    end else begin
      if (pt_q[0] !== '0) begin errors++; $display("FAIL case2_pt_data: got %h expected 0", pt_q[0]); end
      checks++;
      if (acc_cyc.size() != 1 || pt_cyc[0] - acc_cyc[0] != 12) begin
        errors++; $display("FAIL case2_latency: got %0d expected 12", pt_cyc[0] - (acc_cyc.size() > 0 ? acc_cyc[0] : 0));
      end
      checks++;
      if (done_cyc <= pt_cyc[0]) begin errors++; $display("FAIL case2_done_after_pt: done %0d pt %0d", done_cyc, pt_cyc[0]); end
    end
    checks++; if (auth_last !== 1'b1)   begin errors++; $display("FAIL case2_auth_ok: got %b expected 1", auth_last); end
    checks++; if (auth96_last !== 1'b1) begin errors++; $display("FAIL case2_auth_ok_96: got %b expected 1", auth96_last); end
  endtask

  task automatic test_tag_truncation();
    run_case2(T2 ^ 128'h1);
    checks++; if (done_cnt != 1)        begin errors++; $display("FAIL flip_done_count: got %0d expected 1", done_cnt); end
    checks++; if (auth_last !== 1'b0)   begin errors++; $display("FAIL flip_auth_ok_128: got %b expected 0", auth_last); end
    checks++; if (auth96_last !== 1'b1) begin errors++; $display("FAIL flip_auth_ok_96: got %b expected 1", auth96_last); end
  endtask

  task automatic test_back_to_back();
    run_case3(1'b0);
    checks++;
    if (pt_q.size() != 4) begin
      errors++; $display("FAIL case3_pt_count: got %0d expected 4", pt_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pt_q[i] !== P3[i]) begin errors++; $display("FAIL case3_pt%0d: got %h expected %h", i, pt_q[i], P3[i]); end
        checks++;
        if (acc_cyc.size() != 4 || pt_cyc[i] - acc_cyc[i] != 12) begin
          errors++; $display("FAIL case3_latency%0d: got pt at %0d expected 12 after acceptance", i, pt_cyc[i]);
        end
      end
      checks++;
      if (done_cyc <= pt_cyc[3]) begin errors++; $display("FAIL case3_done_after_pt: done %0d pt %0d", done_cyc, pt_cyc[3]); end
    end
    checks++; if (auth_last !== 1'b1)   begin errors++; $display("FAIL case3_auth_ok: got %b expected 1", auth_last); end
    checks++; if (auth96_last !== 1'b1) begin errors++; $display("FAIL case3_auth_ok_96: got %b expected 1", auth96_last); end
  endtask

  task automatic test_backpressure();
    run_case3(1'b1);
    checks++;
    if (pt_q.size() != 4) begin
      errors++; $display("FAIL bp_pt_count: got %0d expected 4", pt_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pt_q[i] !== P3[i]) begin errors++; $display("FAIL bp_pt%0d: got %h expected %h", i, pt_q[i], P3[i]); end
      end
    end
    checks++; if (done_cnt != 1)      begin errors++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
    checks++; if (auth_last !== 1'b1) begin errors++; $display("FAIL bp_auth_ok: got %b expected 1", auth_last); end
  endtask

  task automatic test_reset_mid_message();
    clear_mon();
    do_start(K3, IV3, T3);
    send_beat(1'b0, '0, 1'b0, 1'b1, 0);
    send_beat(1'b1, C3[0], 1'b1, 1'b0, 0);
    send_beat(1'b1, C3[1], 1'b1, 1'b0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    checks++; if (pt_q.size() != 0) begin errors++; $display("FAIL abort_pt_count: got %0d expected 0", pt_q.size()); end
    checks++; if (done_cnt != 0)    begin errors++; $display("FAIL abort_done_count: got %0d expected 0", done_cnt); end
    checks++; if (g.busy !== 1'b0)  begin errors++; $display("FAIL abort_busy: got %b expected 0", g.busy); end
    run_case2(T2);
    checks++; if (pt_q.size() != 1) begin errors++; $display("FAIL rerun_pt_count: got %0d expected 1", pt_q.size()); end
    else begin
      checks++; if (pt_q[0] !== '0) begin errors++; $display("FAIL rerun_pt_data: got %h expected 0", pt_q[0]); end
    end
    checks++; if (auth_last !== 1'b1) begin errors++; $display("FAIL rerun_auth_ok: got %b expected 1", auth_last); end
  endtask

  initial begin
    g.key = '0; g.iv = '0; g.tag_in = '0; g.start = 1'b0;
    g.aad_data = '0; g.aad_valid = 1'b0; g.aad_last = 1'b0;
    g.ct_data = '0; g.ct_valid = 1'b0; g.ct_last = 1'b0;
    test_reset();
    test_empty_message();
    test_single_block();
    test_tag_truncation();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_message();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
